// File: rtl/axi4_sram_slave.sv
// AXI4 slave in front of a single-ported-per-direction word SRAM: one write FSM and
// one read FSM run concurrently, each handling one outstanding burst at a time.
module axi4_sram_slave #(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic [1:0]              AWLOCK,
  input  logic [3:0]              AWCACHE,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [1:0]              ARLOCK,
  input  logic [3:0]              ARCACHE,
  input  logic [2:0]              ARPORT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [DATA_WIDTH/8-1:0] RSTRB,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(OFF_W);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t         w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len;
  logic [7:0]       w_beat;
  logic             w_incr;
  logic             w_legal;
  logic             w_err;
  logic             wr_en;

  r_state_t         r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_idx_nxt;
  logic [7:0]       r_len;
  logic [7:0]       r_beat;
  logic             r_incr;
  logic             r_legal;

  // Lock/cache/prot qualifiers and address bits above the word index carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPORT, AWADDR, ARADDR};

  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst[1] == 1'b0) && (size == FULL_SIZE);
  endfunction

  assign wr_en     = (w_state == W_DATA) && WVALID && WREADY && w_legal;
  assign r_idx_nxt = r_incr ? r_idx + IDX_W'(1) : r_idx;

  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_incr  <= 1'b0;
      w_legal <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          AWREADY <= 1'b1;
          if (AWVALID && AWREADY) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            BID     <= AWID;
            w_idx   <= AWADDR[OFF_W +: IDX_W];
            w_len   <= AWLEN;
            w_beat  <= '0;
            w_incr  <= (AWBURST == 2'b01);
            w_legal <= burst_legal(AWBURST, AWSIZE);
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID && WREADY) begin
            if (w_beat == w_len) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BRESP   <= (!w_legal || w_err || !WLAST) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end else begin
              // A WLAST before the counted end is remembered but the burst still runs to AWLEN.
              if (WLAST) w_err <= 1'b1;
              w_beat <= w_beat + 8'd1;
              if (w_incr) w_idx <= w_idx + IDX_W'(1);
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RSTRB   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_incr  <= 1'b0;
      r_legal <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          ARREADY <= 1'b1;
          if (ARVALID && ARREADY) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RID     <= ARID;
            RSTRB   <= '1;
            RLAST   <= (ARLEN == 8'd0);
            RDATA   <= burst_legal(ARBURST, ARSIZE) ? mem[ARADDR[OFF_W +: IDX_W]] : '0;
            r_idx   <= ARADDR[OFF_W +: IDX_W];
            r_len   <= ARLEN;
            r_beat  <= '0;
            r_incr  <= (ARBURST == 2'b01);
            r_legal <= burst_legal(ARBURST, ARSIZE);
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          // The next beat is fetched on the accepting edge so beats stream without bubbles.
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_beat <= r_beat + 8'd1;
              r_idx  <= r_idx_nxt;
              RDATA  <= r_legal ? mem[r_idx_nxt] : '0;
              RLAST  <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
